// File: rtl/vanilla_pkg.sv
// Shared types and constants for the WISHBONE host bridge.
package vanilla_pkg;

    // Bridge sequencing: wait for a request, run the bus cycle, hold the response.
    typedef enum logic [1:0] {
        WBH_IDLE,
        WBH_BUS,
        WBH_RESP
    } wbh_state_t;

    // Default number of bus cycles to wait for ACK_I before aborting.
    localparam int WBH_TIMEOUT_DEFAULT = 255;

    // Address/data widths of the MMIO bus (mirrors the io_map width macros).
    localparam int WBH_ADDR_W = 21;
    localparam int WBH_DATA_W = 32;

    // Width of a counter that must hold 0..limit; never narrower than one bit.
    function automatic int wbh_cnt_width(input int limit);
        return (limit <= 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wbh_timeout_cnt.sv
// Bus-cycle timeout counter: counts enabled cycles, flags the terminal count,
// saturates instead of wrapping, and never fires when LIMIT is 0.
module wbh_timeout_cnt
    import vanilla_pkg::*;
#(
    parameter int LIMIT = WBH_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int            W      = wbh_cnt_width(LIMIT);
    localparam logic [W-1:0]  TC_VAL = W'((LIMIT > 0) ? (LIMIT - 1) : 0);

    logic [W-1:0] cnt;

    // Count wait cycles; clear wins over enable, and the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (LIMIT != 0) && (cnt == TC_VAL);

endmodule

// File: rtl/wb_host_bridge.sv
// WISHBONE classic single-transfer initiator driven by a valid/ready command
// port; returns read data or a timeout error on a valid/ready response port.
module wb_host_bridge
    import vanilla_pkg::*;
#(
    parameter int ADDR_W      = WBH_ADDR_W,
    parameter int DATA_W      = WBH_DATA_W,
    parameter int TIMEOUT_CYC = WBH_TIMEOUT_DEFAULT
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    // command port
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // WISHBONE initiator
    output logic [ADDR_W-1:0] ADDR_O,
    output logic [DATA_W-1:0] DAT_O,
    input  logic [DATA_W-1:0] DAT_I,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I
);

    wbh_state_t state;
    logic       to_tc;
    logic       to_clear;
    logic       to_en;

    // The counter only runs while waiting on the slave; any exit from BUS clears it.
    assign to_en    = (state == WBH_BUS) && !ACK_I;
    assign to_clear = (state != WBH_BUS) || ACK_I || to_tc;

    wbh_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (CLK_I),
        .rst_n (RST_N_I),
        .clear (to_clear),
        .en    (to_en),
        .tc    (to_tc)
    );

    // Bridge FSM with every output registered; ACK_I beats the timeout on the same edge.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state     <= WBH_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ADDR_O    <= '0;
            DAT_O     <= '0;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
        end else begin
            unique case (state)
                WBH_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= WBH_BUS;
                        req_ready <= 1'b0;
                        CYC_O     <= 1'b1;
                        STB_O     <= 1'b1;
                        WE_O      <= req_we;
                        ADDR_O    <= req_addr;
                        DAT_O     <= req_we ? req_wdata : '0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                WBH_BUS: begin
                    if (ACK_I) begin
                        state     <= WBH_RESP;
                        CYC_O     <= 1'b0;
                        STB_O     <= 1'b0;
                        rsp_rdata <= WE_O ? '0 : DAT_I;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (to_tc) begin
                        state     <= WBH_RESP;
                        CYC_O     <= 1'b0;
                        STB_O     <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                end

                WBH_RESP: begin
                    if (rsp_ready) begin
                        state     <= WBH_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= WBH_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    CYC_O     <= 1'b0;
                    STB_O     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge with a small behavioural WISHBONE slave.
module tb_wb_host_bridge;

    localparam int AW = 21;
    localparam int DW = 32;

    logic          CLK_I = 1'b0;
    logic          RST_N_I;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ADDR_O;
    logic [DW-1:0] DAT_O, DAT_I;
    logic          CYC_O, STB_O, WE_O, ACK_I;

    int checks = 0;
    int errors = 0;

    // slave model controls
    int            ack_delay = -1;   // wait cycles before ACK; -1 = never
    bit            ack_tie   = 1'b0; // unused slot: ACK tied high
    logic [DW-1:0] slv_data  = '0;
    int            slv_n     = 0;

    wb_host_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (4)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_N_I   (RST_N_I),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ADDR_O    (ADDR_O),
        .DAT_O     (DAT_O),
        .DAT_I     (DAT_I),
        .CYC_O     (CYC_O),
        .STB_O     (STB_O),
        .WE_O      (WE_O),
        .ACK_I     (ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    // Slave: raise ACK after ack_delay negedges of CYC_O; junk data unless acking.
    always @(negedge CLK_I) begin
        if (!CYC_O) begin
            slv_n = 0;
            ACK_I = ack_tie;
        end else begin
            ACK_I = ack_tie || (ack_delay >= 0 && slv_n >= ack_delay);
            slv_n = slv_n + 1;
        end
        DAT_I = ACK_I ? slv_data : 32'hBAD0_0000;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one request, then follow it until rsp_valid (bounded).
    task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int cyc, output int redge, output bit stab);
        logic rr;
        bit   hs;
        cyc = 0; redge = -1; stab = 1'b1; hs = 1'b0;
        @(negedge CLK_I);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 40; i++) begin
            rr = req_ready;
            @(posedge CLK_I);
            if (rr) begin
                hs = 1'b1;
                break;
            end
            @(negedge CLK_I);
        end
        #1;
        req_valid = 1'b0;
        if (!hs) begin
            chk("handshake", 64'd0, 64'd1);
            return;
        end
        for (int e = 0; e < 40; e++) begin
            if (CYC_O) begin
                cyc++;
                if (ADDR_O !== a || WE_O !== we || STB_O !== 1'b1 ||
                    DAT_O !== (we ? d : 32'h0))
                    stab = 1'b0;
            end
            if (rsp_valid) begin
                redge = e;
                break;
            end
            @(posedge CLK_I);
            #1;
        end
    endtask

    task automatic accept_rsp(input string tag);
        @(negedge CLK_I);
        rsp_ready = 1'b1;
        @(posedge CLK_I);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    int            cyc, redge;
    bit            stab, ok;
    logic [DW-1:0] held;

    initial begin
        RST_N_I = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cyc", 64'({CYC_O, STB_O, WE_O}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
        chk("rst_bus", 64'({ADDR_O, DAT_O}), 64'd0);
        repeat (2) @(negedge CLK_I);
        RST_N_I = 1'b1;
        @(posedge CLK_I); #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // Write with two wait cycles: CYC high 3 cycles, response 3 edges after handshake.
        ack_delay = 2; slv_data = 32'h1234_5678;
        xfer(1'b1, 21'h000040, 32'hDEAD_BEEF, cyc, redge, stab);
        chk("wr_cyc_len", 64'(cyc), 64'd3);
        chk("wr_stable", 64'(stab), 64'd1);
        chk("wr_rsp_edge", 64'(redge), 64'd3);
        chk("wr_rdata", 64'(rsp_rdata), 64'd0);
        chk("wr_err", 64'(rsp_err), 64'd0);
        accept_rsp("wr");

        // Unused slot, ACK tied high (also stray while idle): CYC 1 cycle.
        ack_tie = 1'b1; ack_delay = -1; slv_data = 32'h0;
        xfer(1'b0, 21'h001F00, 32'h0, cyc, redge, stab);
        chk("unused_cyc_len", 64'(cyc), 64'd1);
        chk("unused_rsp_edge", 64'(redge), 64'd1);
        chk("unused_rdata", 64'(rsp_rdata), 64'd0);
        chk("unused_err", 64'(rsp_err), 64'd0);
        accept_rsp("unused");
        ack_tie = 1'b0;

        // GPO/timer read with one wait cycle.
        ack_delay = 1; slv_data = 32'h0000_00A5;
        xfer(1'b0, 21'h000104, 32'h0, cyc, redge, stab);
        chk("gpo_cyc_len", 64'(cyc), 64'd2);
        chk("gpo_stable", 64'(stab), 64'd1);
        chk("gpo_rdata", 64'(rsp_rdata), 64'h0000_00A5);
        chk("gpo_err", 64'(rsp_err), 64'd0);
        accept_rsp("gpo");

        // Timeout: no ACK, limit 4.
        ack_delay = -1; slv_data = 32'hFFFF_FFFF;
        xfer(1'b0, 21'h000200, 32'h0, cyc, redge, stab);
        chk("to_cyc_len", 64'(cyc), 64'd4);
        chk("to_rsp_edge", 64'(redge), 64'd4);
        chk("to_err", 64'(rsp_err), 64'd1);
        chk("to_rdata", 64'(rsp_rdata), 64'd0);
        accept_rsp("to");

        // ACK on the terminal edge beats the timeout.
        ack_delay = 3; slv_data = 32'h0BAD_CAFE;
        xfer(1'b0, 21'h000204, 32'h0, cyc, redge, stab);
        chk("to_ack_cyc_len", 64'(cyc), 64'd4);
        chk("to_ack_err", 64'(rsp_err), 64'd0);
        chk("to_ack_rdata", 64'(rsp_rdata), 64'h0BAD_CAFE);
        accept_rsp("to_ack");

        // Backpressure: response held, next request waits.
        ack_delay = 0; slv_data = 32'h5A5A_0001;
        xfer(1'b0, 21'h000300, 32'h0, cyc, redge, stab);
        chk("bp_first_rdata", 64'(rsp_rdata), 64'h5A5A_0001);
        held = rsp_rdata;
        @(negedge CLK_I);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 21'h000308; req_wdata = 32'h0000_1111;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_I);
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_err !== 1'b0 ||
                req_ready !== 1'b0 || CYC_O !== 1'b0)
                ok = 1'b0;
        end
        chk("bp_hold", 64'(ok), 64'd1);
        rsp_ready = 1'b1;
        @(posedge CLK_I); #1;
        rsp_ready = 1'b0;
        chk("bp_release", 64'({rsp_valid, req_ready, CYC_O}), 64'b010);
        @(posedge CLK_I); #1;
        req_valid = 1'b0;
        chk("bp_next_cyc", 64'({CYC_O, STB_O, WE_O}), 64'b111);
        chk("bp_next_addr", 64'(ADDR_O), 64'h000308);
        chk("bp_next_dat", 64'(DAT_O), 64'h0000_1111);
        @(posedge CLK_I); #1;
        chk("bp_next_rsp", 64'({rsp_valid, rsp_err}), 64'b10);
        accept_rsp("bp");

        // Asynchronous reset while CYC_O is high.
        ack_delay = -1;
        @(negedge CLK_I);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 21'h000400;
        @(posedge CLK_I); #1;
        req_valid = 1'b0;
        chk("mid_cyc_up", 64'(CYC_O), 64'd1);
        @(negedge CLK_I); #2;
        RST_N_I = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({CYC_O, STB_O, rsp_valid, req_ready}), 64'd0);
        @(negedge CLK_I);
        RST_N_I = 1'b1;
        @(posedge CLK_I); #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0 || CYC_O !== 1'b0) ok = 1'b0;
            @(posedge CLK_I); #1;
        end
        chk("mid_no_stale", 64'(ok), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
